// File: rtl/shift_insert_pkg.sv
// Shared definitions for the TX header/payload re-packer: bus widths, state
// encoding, default geometry and the internal output-beat bundle.
package shift_insert_pkg;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned KEEP_W = 32;

  localparam int unsigned DEF_HDR_BEATS  = 4;
  localparam int unsigned DEF_TAIL_BYTES = 10;
  localparam logic [15:0] DEF_TYPE_VALUE = 16'h0008;

  typedef logic [1:0] state_t;
  localparam state_t ST_HDR   = 2'd0;
  localparam state_t ST_PAY   = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  // Contiguous byte-enable mask with the low n lanes set.
  function automatic logic [KEEP_W-1:0] low_keep(input int unsigned n);
    logic [KEEP_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/shift_insert_if.sv
// Input stream and output stream of shift_insert, kept under their original
// signal names so existing connections map one-to-one.
interface shift_insert_if;
  import shift_insert_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  logic [DATA_W-1:0] dout;
  logic [KEEP_W-1:0] keep;
  logic              valid;
  logic              last;
  logic              ready;

  modport slave (
    input  tdata, tkeep, tvalid, tlast, ready,
    output tready, dout, keep, valid, last
  );

  modport master (
    output tdata, tkeep, tvalid, tlast, ready,
    input  tready, dout, keep, valid, last
  );

endinterface

// File: rtl/shift_insert_axis_out_reg.sv
// Single-entry registered AXI-Stream output stage: loads only when empty or
// being drained, otherwise holds data/keep/last stable.
module axis_out_reg
  import shift_insert_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  logic  load,
  input  beat_t load_beat,
  output logic  free,
  output beat_t out_beat,
  output logic  out_valid,
  input  logic  out_ready
);

  assign free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (free) begin
      out_valid <= load;
      if (load) out_beat <= load_beat;
    end
  end

endmodule

// File: rtl/shift_insert.sv
// TX re-packer: passes header beats, merges the tail of the last header beat
// with the byte-0-aligned payload, and emits a flush beat when bytes spill over.
module shift_insert
  import shift_insert_pkg::*;
#(
  parameter int unsigned HDR_BEATS  = DEF_HDR_BEATS,
  parameter int unsigned TAIL_BYTES = DEF_TAIL_BYTES,
  parameter bit          TYPE_EN    = 1'b1,
  parameter logic [15:0] TYPE_VALUE = DEF_TYPE_VALUE
) (
  input logic          clk,
  input logic          resetn,
  shift_insert_if.slave s
);

  localparam int unsigned SHIFT = KEEP_W - TAIL_BYTES;
  localparam int unsigned IDX_W = (HDR_BEATS > 2) ? $clog2(HDR_BEATS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HDR_BEATS - 1);
  localparam logic [IDX_W-1:0] IDX_TYPE = IDX_W'(1);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [8*TAIL_BYTES-1:0] carry;
  logic [TAIL_BYTES-1:0]   carry_keep;

  logic  free;
  logic  accept;
  logic  load;
  beat_t load_beat;
  beat_t out_beat;
  logic  out_valid;

  assign s.tready = free && (state != ST_FLUSH);
  assign accept   = s.tvalid && s.tready;

  // The last header beat of a packet with payload is absorbed into carry,
  // so it produces no load; the merged beat appears with the first payload.
  always_comb begin
    load      = 1'b0;
    load_beat = '0;
    case (state)
      ST_HDR: begin
        if (accept && (idx != IDX_LAST || s.tlast)) begin
          load           = 1'b1;
          load_beat.data = s.tdata;
          load_beat.keep = s.tkeep;
          load_beat.last = s.tlast;
          if (TYPE_EN && idx == IDX_TYPE && idx != IDX_LAST)
            load_beat.data[111:96] = TYPE_VALUE;
        end
      end
      ST_PAY: begin
        if (accept) begin
          load           = 1'b1;
          load_beat.data = {s.tdata[8*SHIFT-1:0], carry};
          load_beat.keep = {s.tkeep[SHIFT-1:0], {TAIL_BYTES{1'b1}}};
          load_beat.last = s.tlast && !s.tkeep[SHIFT];
        end
      end
      ST_FLUSH: begin
        if (free) begin
          load           = 1'b1;
          load_beat.data = {{(8*SHIFT){1'b0}}, carry};
          load_beat.keep = {{SHIFT{1'b0}}, carry_keep};
          load_beat.last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_HDR;
      idx        <= '0;
      carry      <= '0;
      carry_keep <= '0;
    end else begin
      case (state)
        ST_HDR: begin
          if (accept) begin
            if (s.tlast) begin
              idx <= '0;
            end else if (idx == IDX_LAST) begin
              carry <= s.tdata[8*TAIL_BYTES-1:0];
              idx   <= '0;
              state <= ST_PAY;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_PAY: begin
          if (accept) begin
            carry <= s.tdata[DATA_W-1 -: 8*TAIL_BYTES];
            if (s.tlast) begin
              if (s.tkeep[SHIFT]) begin
                carry_keep <= s.tkeep[KEEP_W-1:SHIFT];
                state      <= ST_FLUSH;
              end else begin
                state <= ST_HDR;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (free) begin
            idx   <= '0;
            state <= ST_HDR;
          end
        end
        default: state <= ST_HDR;
      endcase
    end
  end

  axis_out_reg u_out (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load),
    .load_beat (load_beat),
    .free      (free),
    .out_beat  (out_beat),
    .out_valid (out_valid),
    .out_ready (s.ready)
  );

  assign s.dout  = out_beat.data;
  assign s.keep  = out_beat.keep;
  assign s.last  = out_beat.last;
  assign s.valid = out_valid;

endmodule

// File: tb/tb_shift_insert.sv
// Self-checking bench for shift_insert: random packets against a byte-stream
// reference model, plus directed flush, backpressure and reset scenarios.
module tb_shift_insert;
  import shift_insert_pkg::*;

  localparam int HDR  = 4;
  localparam int TAIL = 10;

  typedef struct {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
  } tb_beat_t;

  logic clk = 1'b0;
  logic resetn;
  logic rdy_r = 1'b0;
  int   ready_mode = 0;   // 0: ready=1, 1: random, 2: toggle, 3: ready=0

  shift_insert_if bus();

  shift_insert #(
    .HDR_BEATS (HDR),
    .TAIL_BYTES(TAIL),
    .TYPE_EN   (1'b1),
    .TYPE_VALUE(16'h0008)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .s     (bus)
  );

  always #5 clk = ~clk;

  assign bus.ready = (ready_mode == 0) ? 1'b1 :
                     (ready_mode == 3) ? 1'b0 : rdy_r;

  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) rdy_r = 1'($urandom_range(0, 1));
    else                 rdy_r = ~rdy_r;
  end

  tb_beat_t exp_q[$];
  tb_beat_t got_q[$];
  tb_beat_t pkt_q[$];
  int errors = 0;
  int checks = 0;
  int stab_err = 0;
  int flush_cnt = 0;

  logic         hold = 1'b0;
  logic [255:0] h_d;
  logic [31:0]  h_k;
  logic         h_l;

  always @(negedge clk) begin
    tb_beat_t mb;
    if (resetn) begin
      if (hold && (bus.valid !== 1'b1 || bus.dout !== h_d || bus.keep !== h_k || bus.last !== h_l))
        stab_err++;
      if (bus.valid && !bus.ready && bus.tready) stab_err++;
      if (bus.ready && !bus.tready) flush_cnt++;
      if (bus.valid && bus.ready) begin
        mb.d = bus.dout; mb.k = bus.keep; mb.l = bus.last;
        got_q.push_back(mb);
      end
      hold = bus.valid && !bus.ready;
      h_d = bus.dout; h_k = bus.keep; h_l = bus.last;
    end else begin
      hold = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: headers pass through, everything after the last header's
  // tail is treated as one byte stream and re-chunked into 32-byte beats.
  task automatic model_pkt();
    int n;
    logic [7:0] bq[$];
    tb_beat_t b;
    n = pkt_q.size();
    for (int i = 0; i < n && (i < HDR - 1 || n <= HDR); i++) begin
      b = pkt_q[i];
      if (i == 1 && i < HDR - 1) b.d[111:96] = 16'h0008;
      exp_q.push_back(b);
    end
    if (n > HDR) begin
      for (int j = 0; j < TAIL; j++) bq.push_back(pkt_q[HDR-1].d[8*j +: 8]);
      for (int i = HDR; i < n; i++)
        for (int j = 0; j < 32; j++)
          if (pkt_q[i].k[j]) bq.push_back(pkt_q[i].d[8*j +: 8]);
      while (bq.size() > 0) begin
        b.d = '0; b.k = '0;
        for (int j = 0; j < 32; j++) begin
          if (bq.size() > 0) begin
            b.d[8*j +: 8] = bq.pop_front();
            b.k[j] = 1'b1;
          end
        end
        b.l = (bq.size() == 0);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic make_pkt(input int n, input int last_k);
    tb_beat_t b;
    pkt_q.delete();
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < 8; w++) b.d[32*w +: 32] = $urandom;
      b.k = '1;
      b.l = (i == n - 1);
      if (b.l) begin
        b.k = (last_k >= 32) ? 32'hFFFF_FFFF : ((32'h1 << last_k) - 32'h1);
        for (int j = 0; j < 32; j++) if (!b.k[j]) b.d[8*j +: 8] = 8'h00;
      end
      pkt_q.push_back(b);
    end
  endtask

  task automatic drive_beat(input tb_beat_t b);
    int cyc;
    bus.tdata = b.d; bus.tkeep = b.k; bus.tlast = b.l; bus.tvalid = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (bus.tready) break;
      cyc++;
      if (cyc > 500) begin
        checks++; errors++;
        $display("FAIL accept_timeout: tready=%b after %0d cycles, required 1", bus.tready, cyc);
        break;
      end
    end
    @(posedge clk); #1;
    bus.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input bit gaps);
    model_pkt();
    for (int i = 0; i < pkt_q.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      drive_beat(pkt_q[i]);
    end
  endtask

  task automatic drain(input int gb, input int eb);
    int c;
    c = 0;
    while ((got_q.size() - gb) < (exp_q.size() - eb) && c < 400) begin
      @(negedge clk); c++;
    end
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
    checks++; if (bus.last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", bus.last); end
    checks++; if (bus.dout !== '0) begin errors++; $display("FAIL reset_dout got=%h exp=0", bus.dout); end
    checks++; if (bus.keep !== '0) begin errors++; $display("FAIL reset_keep got=%h exp=0", bus.keep); end
    checks++; if (bus.tready !== 1'b1) begin errors++; $display("FAIL reset_tready got=%b exp=1", bus.tready); end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_partial_last();
    int gb, eb, fb;
    gb = got_q.size(); eb = exp_q.size(); fb = flush_cnt;
    make_pkt(6, 16);
    send_pkt(1'b0);
    drain(gb, eb);
    checks++;
    if (got_q.size() - gb !== exp_q.size() - eb) begin errors++;
      $display("FAIL partial_count got=%0d exp=%0d", got_q.size() - gb, exp_q.size() - eb); end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      checks++;
      if (got_q[gb+i].d !== exp_q[eb+i].d || got_q[gb+i].k !== exp_q[eb+i].k || got_q[gb+i].l !== exp_q[eb+i].l) begin
        errors++;
        $display("FAIL partial_beat%0d got %h/%h/%b exp %h/%h/%b", i, got_q[gb+i].d, got_q[gb+i].k, got_q[gb+i].l,
                 exp_q[eb+i].d, exp_q[eb+i].k, exp_q[eb+i].l);
      end
    end
    if (got_q.size() - gb > 4) begin
      checks++;
      if (got_q[gb+4].k !== 32'h03FF_FFFF) begin errors++;
        $display("FAIL partial_last_keep got=%h exp=03ffffff", got_q[gb+4].k); end
    end
    checks++;
    if (flush_cnt - fb !== 0) begin errors++; $display("FAIL partial_no_flush got=%0d exp=0", flush_cnt - fb); end
  endtask

  task automatic test_flush();
    int gb, eb, fb;
    gb = got_q.size(); eb = exp_q.size(); fb = flush_cnt;
    make_pkt(6, 32);
    send_pkt(1'b0);
    drain(gb, eb);
    checks++;
    if (got_q.size() - gb !== 6) begin errors++; $display("FAIL flush_count got=%0d exp=6", got_q.size() - gb); end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      checks++;
      if (got_q[gb+i].d !== exp_q[eb+i].d || got_q[gb+i].k !== exp_q[eb+i].k || got_q[gb+i].l !== exp_q[eb+i].l) begin
        errors++;
        $display("FAIL flush_beat%0d got %h/%h/%b exp %h/%h/%b", i, got_q[gb+i].d, got_q[gb+i].k, got_q[gb+i].l,
                 exp_q[eb+i].d, exp_q[eb+i].k, exp_q[eb+i].l);
      end
    end
    if (got_q.size() - gb > 5) begin
      checks++;
      if (got_q[gb+5].k !== 32'h0000_03FF || got_q[gb+5].l !== 1'b1) begin errors++;
        $display("FAIL flush_beat_keep got=%h/%b exp=000003ff/1", got_q[gb+5].k, got_q[gb+5].l); end
    end
    checks++;
    if (flush_cnt - fb !== 1) begin errors++; $display("FAIL flush_tready_low got=%0d cycles exp=1", flush_cnt - fb); end
  endtask

  task automatic test_header_only();
    int gb, eb;
    gb = got_q.size(); eb = exp_q.size();
    make_pkt(4, 24);
    send_pkt(1'b0);
    drain(gb, eb);
    checks++;
    if (got_q.size() - gb !== 4) begin errors++; $display("FAIL hdronly_count got=%0d exp=4", got_q.size() - gb); end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      checks++;
      if (got_q[gb+i].d !== exp_q[eb+i].d || got_q[gb+i].k !== exp_q[eb+i].k || got_q[gb+i].l !== exp_q[eb+i].l) begin
        errors++;
        $display("FAIL hdronly_beat%0d got %h/%h/%b exp %h/%h/%b", i, got_q[gb+i].d, got_q[gb+i].k, got_q[gb+i].l,
                 exp_q[eb+i].d, exp_q[eb+i].k, exp_q[eb+i].l);
      end
    end
    if (got_q.size() - gb > 3) begin
      checks++;
      if (got_q[gb+3].d !== pkt_q[3].d || got_q[gb+3].k !== 32'h00FF_FFFF || got_q[gb+3].l !== 1'b1) begin errors++;
        $display("FAIL hdronly_last got=%h/%b exp=00ffffff/1 with unchanged data", got_q[gb+3].k, got_q[gb+3].l); end
    end
  endtask

  task automatic test_backpressure();
    int gb, eb, sb;
    gb = got_q.size(); eb = exp_q.size(); sb = stab_err;
    ready_mode = 2;
    make_pkt(7, 20);
    send_pkt(1'b1);
    drain(gb, eb);
    ready_mode = 0;
    checks++;
    if (got_q.size() - gb !== exp_q.size() - eb) begin errors++;
      $display("FAIL bp_count got=%0d exp=%0d", got_q.size() - gb, exp_q.size() - eb); end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      checks++;
      if (got_q[gb+i].d !== exp_q[eb+i].d || got_q[gb+i].k !== exp_q[eb+i].k || got_q[gb+i].l !== exp_q[eb+i].l) begin
        errors++;
        $display("FAIL bp_beat%0d got %h/%h/%b exp %h/%h/%b", i, got_q[gb+i].d, got_q[gb+i].k, got_q[gb+i].l,
                 exp_q[eb+i].d, exp_q[eb+i].k, exp_q[eb+i].l);
      end
    end
    checks++;
    if (stab_err - sb !== 0) begin errors++; $display("FAIL bp_stability violations=%0d exp=0", stab_err - sb); end
  endtask

  task automatic test_reset_midpacket();
    int gb, eb;
    make_pkt(7, 32);
    for (int i = 0; i < 5; i++) drive_beat(pkt_q[i]);
    ready_mode = 3;
    checks++;
    if (bus.valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got=%b exp=1", bus.valid); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", bus.valid); end
    checks++; if (bus.dout !== '0 || bus.keep !== '0 || bus.last !== 1'b0) begin errors++;
      $display("FAIL midrst_outputs got=%h/%h/%b exp=0/0/0", bus.dout, bus.keep, bus.last); end
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    ready_mode = 0;
    gb = got_q.size(); eb = exp_q.size();
    make_pkt(6, 16);
    send_pkt(1'b1);
    drain(gb, eb);
    checks++;
    if (got_q.size() - gb !== exp_q.size() - eb) begin errors++;
      $display("FAIL midrst_count got=%0d exp=%0d", got_q.size() - gb, exp_q.size() - eb); end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      checks++;
      if (got_q[gb+i].d !== exp_q[eb+i].d || got_q[gb+i].k !== exp_q[eb+i].k || got_q[gb+i].l !== exp_q[eb+i].l) begin
        errors++;
        $display("FAIL midrst_beat%0d got %h/%h/%b exp %h/%h/%b", i, got_q[gb+i].d, got_q[gb+i].k, got_q[gb+i].l,
                 exp_q[eb+i].d, exp_q[eb+i].k, exp_q[eb+i].l);
      end
    end
  endtask

  task automatic test_back_to_back();
    int gb, eb, fb, first_len;
    gb = got_q.size(); eb = exp_q.size(); fb = flush_cnt;
    make_pkt(5, 32);
    send_pkt(1'b0);
    make_pkt(6, 32);
    send_pkt(1'b0);
    drain(gb, eb);
    first_len = 0;
    for (int i = gb; i < got_q.size(); i++) begin
      if (first_len == 0 && got_q[i].l) first_len = i - gb + 1;
    end
    checks++;
    if (first_len !== 5) begin errors++; $display("FAIL b2b_first_len got=%0d exp=5", first_len); end
    checks++;
    if (got_q.size() - gb - first_len !== 6) begin errors++;
      $display("FAIL b2b_second_len got=%0d exp=6", got_q.size() - gb - first_len); end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      checks++;
      if (got_q[gb+i].d !== exp_q[eb+i].d || got_q[gb+i].k !== exp_q[eb+i].k || got_q[gb+i].l !== exp_q[eb+i].l) begin
        errors++;
        $display("FAIL b2b_beat%0d got %h/%h/%b exp %h/%h/%b", i, got_q[gb+i].d, got_q[gb+i].k, got_q[gb+i].l,
                 exp_q[eb+i].d, exp_q[eb+i].k, exp_q[eb+i].l);
      end
    end
    checks++;
    if (flush_cnt - fb !== 2) begin errors++; $display("FAIL b2b_flushes got=%0d exp=2", flush_cnt - fb); end
  endtask

  task automatic test_random();
    int gb, eb, sb;
    gb = got_q.size(); eb = exp_q.size(); sb = stab_err;
    ready_mode = 1;
    for (int p = 0; p < 12; p++) begin
      make_pkt($urandom_range(1, 8), $urandom_range(1, 32));
      send_pkt(1'b1);
    end
    drain(gb, eb);
    ready_mode = 0;
    checks++;
    if (got_q.size() - gb !== exp_q.size() - eb) begin errors++;
      $display("FAIL rand_count got=%0d exp=%0d", got_q.size() - gb, exp_q.size() - eb); end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      checks++;
      if (got_q[gb+i].d !== exp_q[eb+i].d || got_q[gb+i].k !== exp_q[eb+i].k || got_q[gb+i].l !== exp_q[eb+i].l) begin
        errors++;
        $display("FAIL rand_beat%0d got %h/%h/%b exp %h/%h/%b", i, got_q[gb+i].d, got_q[gb+i].k, got_q[gb+i].l,
                 exp_q[eb+i].d, exp_q[eb+i].k, exp_q[eb+i].l);
      end
    end
    checks++;
    if (stab_err - sb !== 0) begin errors++; $display("FAIL rand_stability violations=%0d exp=0", stab_err - sb); end
  endtask

  initial begin
    resetn     = 1'b0;
    bus.tdata  = '0;
    bus.tkeep  = '0;
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
    test_reset();
    test_partial_last();
    test_flush();
    test_header_only();
    test_backpressure();
    test_reset_midpacket();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
